ifft_1d_4_stream: RTL
=====================

Name: ifft_1d_4_stream

Overview:
Streaming 4-point inverse FFT, the decode side of the 4-point forward FFT path. It accepts frequency-domain complex samples one per clock in natural order X0..X3. It outputs the time-domain complex samples x0..x3 in natural order, scaled by 1/4. It sits after the forward FFT, or after any spectral processing, to close the round trip.

Parameters:
N, 4, transform length; fixed, and the only supported value.
W, 16, sample width per real/imag component, signed Q8.8; 0x0100 = 1.0.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_r/in_i hold a valid spectral sample this cycle
in_r  input  W  signed real part of X[k]
in_i  input  W  signed imaginary part of X[k]
out_valid  output  1  out_r/out_i hold a valid time sample
out_r  output  W  signed real part of x[n]
out_i  output  W  signed imaginary part of x[n]
out_last  output  1  high together with x3, the last sample of a frame

Behaviour:
- Reset (rst=1 at an edge) clears the following:
  - out_valid=0, out_last=0, out_r=0, out_i=0
  - input counter in_cnt=0 and output counter out_cnt=0
  - the result-bank-full flag
  - any partially collected or partially drained frame is discarded
- Input collection:
  - each edge with in_valid=1 writes the sample to buffer[in_cnt] and increments in_cnt (2-bit, wraps 3→0).
  - in_valid=0 holds in_cnt; gaps are allowed at any point.
- Frame completion: the edge that captures in_cnt=3 (edge E) raises frame_ready for one cycle.
- Compute: at edge E+1, all four results are computed from the buffer and written to the result bank.
  - x0=(X0+X1+X2+X3)/4
  - x1=(X0+jX1−X2−jX3)/4
  - x2=(X0−X1+X2−X3)/4
  - x3=(X0−jX1−X2+jX3)/4
  - multiplying by ±j swaps the components and negates one of them; there are no multipliers.
- Arithmetic and widths:
  - sums are formed at W+2 bits, then arithmetic-shifted right by 2 back to W bits.
  - the result always fits in W bits, so no saturation is needed.
- Output drain:
  - edge E+1 also presents x0 with out_valid=1.
  - edges E+2, E+3, E+4 present x1, x2, x3; out_last=1 with x3 only.
  - the next edge drops out_valid and out_last.
  - out_r/out_i hold their last value while out_valid=0.
- Latency: 1 cycle from capture of X3 to x0 valid; the drain lasts exactly 4 cycles.
- Throughput: back-to-back frames at 1 sample/cycle are supported. The next frame's X3 arrives no earlier than E+4, so its bank load at E+5 follows x3 seamlessly (out_valid stays high).
- Buffering: the input buffer may be overwritten while the bank drains. The bank is only reloaded after a full 4-cycle drain, so no overflow is possible and no backpressure port exists.
- Reset mid-operation: rst has priority over in_valid and the drain. The first in_valid sample after reset is X0 of a new frame.

Optional Feature:
Macro IFFT_ROUND_EN.
- Defined: add 2 to each W+2-bit sum before the >>>2, giving round-half-up.
- Undefined: plain arithmetic shift, giving floor.
- Widths, latency and handshake are identical in both builds.

Decomposition:
- Shared defines header holds the existing `InBus/`OutBus bus ranges, W, N and the Q8.8 ONE constant (0x0100).
- One natural sub-module: ifft4_butterfly. It is purely combinational, takes 4 complex inputs and gives 4 scaled complex outputs, and is where the rounding macro is applied.
- The top level holds the counters, buffer, result bank and drain logic.

Test Plan:
- Impulse: X=[0x0400+j0, 0, 0, 0] → x0..x3 all 0x0100+j0, out_last with x3, out_valid high for exactly 4 cycles.
- Single bin: X1=0x0400 only → x0=(0x0100,0), x1=(0,0x0100), x2=(0xFF00,0), x3=(0,0xFF00).
- Round trip: forward-FFT spectrum of the ramp [0, 1+j, 2+2j, 3+3j] is fed in as X=[(0x0600,0x0600),(0xFC00,0),(0xFE00,0xFE00),(0,0xFC00)] → out (0,0),(0x0100,0x0100),(0x0200,0x0200),(0x0300,0x0300).
- Rounding: X0=0x0002 alone → 0x0000 floor / 0x0001 with IFFT_ROUND_EN. X0=0xFFFE alone → 0xFFFF floor / 0x0000 rounded.
- Streaming and gaps: two frames back-to-back, then a frame with in_valid low for 3 cycles between X1 and X2 → 8 consecutive valid outputs for the first two frames, and the third frame's x0 exactly 1 cycle after its X3.
- Reset mid-frame: rst after X0,X1 captured, then 4 fresh samples → only the fresh frame is output. Reset during the drain → out_valid=0 on the next cycle, and no remaining samples are emitted.

Source files
------------

// File: rtl/ifft_1d_4_stream_pkg.sv
// Shared constants and types for the streaming 4-point inverse FFT.
// Optional build macro IFFT_ROUND_EN (round-half-up scaling) is consumed by ifft4_butterfly.
package ifft_1d_4_stream_pkg;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = W + 2;

    // Q8.8 unity
    localparam logic signed [W-1:0] ONE = 16'sh0100;

    typedef struct packed {
        logic signed [W-1:0] r;
        logic signed [W-1:0] i;
    } cplx_t;

    typedef cplx_t [N-1:0] frame_t;

endpackage

// File: rtl/ifft_1d_4_stream_butterfly.sv
// Combinational 4-point inverse DFT with 1/4 scaling, no multipliers.
// IFFT_ROUND_EN selects round-half-up instead of floor on the final >>>2.
module ifft4_butterfly
    import ifft_1d_4_stream_pkg::*;
(
    input  frame_t spec,
    output frame_t td
);

    function automatic logic signed [SW-1:0] ext(input logic signed [W-1:0] v);
        return {{2{v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] scale(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] t;
`ifdef IFFT_ROUND_EN
        t = s + SW'(2);
`else
        t = s;
`endif
        return t[SW-1:2];
    endfunction

    logic signed [SW-1:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;

    assign x0r = ext(spec[0].r);
    assign x0i = ext(spec[0].i);
    assign x1r = ext(spec[1].r);
    assign x1i = ext(spec[1].i);
    assign x2r = ext(spec[2].r);
    assign x2i = ext(spec[2].i);
    assign x3r = ext(spec[3].r);
    assign x3i = ext(spec[3].i);

    // j*(a+jb) = -b + ja, so the +/-j terms trade real and imaginary parts
    always_comb begin
        td[0].r = scale(x0r + x1r + x2r + x3r);
        td[0].i = scale(x0i + x1i + x2i + x3i);
        td[1].r = scale(x0r - x1i - x2r + x3i);
        td[1].i = scale(x0i + x1r - x2i - x3r);
        td[2].r = scale(x0r - x1r + x2r - x3r);
        td[2].i = scale(x0i - x1i + x2i - x3i);
        td[3].r = scale(x0r + x1i - x2r - x3i);
        td[3].i = scale(x0i - x1r - x2i + x3r);
    end

endmodule

// File: rtl/ifft_1d_4_stream.sv
// Streaming 4-point IFFT: collects X0..X3, computes once, drains x0..x3 in natural order.
// Build macro IFFT_ROUND_EN enables round-half-up scaling in the butterfly.
module ifft_1d_4_stream
    import ifft_1d_4_stream_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_r,
    input  logic [W-1:0] in_i,
    output logic         out_valid,
    output logic [W-1:0] out_r,
    output logic [W-1:0] out_i,
    output logic         out_last
);

    frame_t     buffer;
    frame_t     bank;
    frame_t     res;
    logic [1:0] in_cnt;
    logic [1:0] out_cnt;
    logic       frame_ready;
    logic       bank_full;

    ifft4_butterfly u_bfly (
        .spec (buffer),
        .td   (res)
    );

    // NOTE: sample storage carries no reset; counters and flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            buffer[in_cnt] <= '{r: in_r, i: in_i};
        end
        if (!rst && frame_ready) begin
            bank <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt      <= '0;
            frame_ready <= 1'b0;
        end else begin
            frame_ready <= in_valid && (in_cnt == 2'd3);
            if (in_valid) begin
                in_cnt <= in_cnt + 2'd1;
            end
        end
    end

    // x0 bypasses the bank so it appears on the same edge the bank loads
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_cnt   <= '0;
            bank_full <= 1'b0;
        end else if (frame_ready) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_r     <= res[0].r;
            out_i     <= res[0].i;
            out_cnt   <= 2'd1;
            bank_full <= 1'b1;
        end else if (bank_full) begin
            out_valid <= 1'b1;
            out_last  <= (out_cnt == 2'd3);
            out_r     <= bank[out_cnt].r;
            out_i     <= bank[out_cnt].i;
            out_cnt   <= out_cnt + 2'd1;
            if (out_cnt == 2'd3) begin
                bank_full <= 1'b0;
            end
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
